otsu_threshold: RTL and testbench

Streaming Otsu threshold estimator sitting directly downstream of `image_read`, in parallel with `image_write`, on the two-pixel-per-clock RGB bus. It converts each pixel to grey, builds a 256-bin histogram over one frame and, after the frame ends, sweeps the histogram to find the threshold that maximises between-class variance. The resulting 8-bit threshold is held for the binarisation stage.

---
 rtl/otsu_threshold.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_otsu_threshold.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/otsu_threshold.sv
// ============================================================================
//  Module   : otsu_threshold
//  Purpose  : Streaming Otsu threshold estimator on a two-pixel-per-clock RGB
//             bus. Builds a 256-bin grey histogram over one frame, then sweeps
//             it to find the threshold maximising between-class variance.
//  Ports    : HCLK/HRESETn       clock, async active-low reset
//             hsync, DATA_*0/1   pixel-pair strobe and RGB data (two pixels)
//             THRESHOLD          8-bit result (class 0 is grey <= THRESHOLD)
//             thr_valid          result for the last frame is held
//             thr_done           one-cycle pulse when the result appears
//             busy               accumulating a frame or sweeping
//             overrun            sticky: hsync seen while sweeping
//             hist_addr/hist_data (only with OTSU_HIST_READ_EN) registered
//                                debug read of the histogram
//  Config   : define OTSU_HIST_READ_EN to add the histogram debug read port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module otsu_threshold #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int CNT_W  = 20
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             hsync,
  input  logic [7:0]       DATA_R0,
  input  logic [7:0]       DATA_G0,
  input  logic [7:0]       DATA_B0,
  input  logic [7:0]       DATA_R1,
  input  logic [7:0]       DATA_G1,
  input  logic [7:0]       DATA_B1,
`ifdef OTSU_HIST_READ_EN
  input  logic [7:0]       hist_addr,
  output logic [CNT_W-1:0] hist_data,
`endif
  output logic [7:0]       THRESHOLD,
  output logic             thr_valid,
  output logic             thr_done,
  output logic             busy,
  output logic             overrun
);

  localparam int SUM_W  = CNT_W + 8;
  localparam int PROD_W = 2 * CNT_W + 8;
  localparam int NUM_W  = 2 * PROD_W;
  localparam int DEN_W  = 2 * CNT_W;
  localparam int CMP_W  = NUM_W + DEN_W;
  localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(WIDTH * HEIGHT);
  // Sweep counter value in the cycle before the result edge:
  // 256 bins plus three pipeline drain cycles.
  localparam logic [8:0]       LAST_CNT = 9'd259;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_SWEEP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [7:0] grey(input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b);
    logic [9:0] s;
    s = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return s[9:2];
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hist_q [256];
  logic [CNT_W-1:0] hist_d [256];
  logic [CNT_W-1:0] n_q, n_d;
  logic [SUM_W-1:0] st_q, st_d;
  logic [8:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] w0_q, w0_d;
  logic [SUM_W-1:0] s0_q, s0_d;
  // stage 0 -> 1
  logic             p0_v_q, p0_v_d;
  logic [7:0]       p0_t_q, p0_t_d;
  // stage 1 -> 2
  logic             p1_v_q, p1_v_d;
  logic [7:0]       p1_t_q, p1_t_d;
  logic [PROD_W-1:0] p1_diff_q, p1_diff_d;
  logic [DEN_W-1:0] p1_den_q, p1_den_d;
  // stage 2 -> 3
  logic             p2_v_q, p2_v_d;
  logic [7:0]       p2_t_q, p2_t_d;
  logic [NUM_W-1:0] p2_num_q, p2_num_d;
  logic [DEN_W-1:0] p2_den_q, p2_den_d;
  // best candidate so far
  logic             best_v_q, best_v_d;
  logic [7:0]       best_t_q, best_t_d;
  logic [NUM_W-1:0] best_num_q, best_num_d;
  logic [DEN_W-1:0] best_den_q, best_den_d;
  // outputs
  logic [7:0]       thr_q, thr_d;
  logic             thr_valid_q, thr_valid_d;
  logic             thr_done_q, thr_done_d;
  logic             overrun_q, overrun_d;

  logic [7:0]       g0, g1, t_w;
  logic             accept, clear, sweep_act, last_cyc;
  logic [CNT_W-1:0] h_t;
  logic [PROD_W-1:0] prod_a, prod_b;
  logic [CMP_W-1:0] cmp_lhs, cmp_rhs;

  assign g0        = grey(DATA_R0, DATA_G0, DATA_B0);
  assign g1        = grey(DATA_R1, DATA_G1, DATA_B1);
  assign accept    = hsync && (state_q != S_SWEEP);
  // First pair after a result wipes the previous frame before being counted.
  assign clear     = hsync && (state_q == S_DONE);
  assign sweep_act = (state_q == S_SWEEP) && !cnt_q[8];
  assign last_cyc  = (state_q == S_SWEEP) && (cnt_q == LAST_CNT);
  assign t_w       = cnt_q[7:0];
  assign h_t       = hist_q[t_w];

  always_comb begin
    for (int i = 0; i < 256; i++) begin
      hist_d[i] = clear ? '0 : hist_q[i];
      if (accept) begin
        // Equal grey values naturally give the bin +2.
        hist_d[i] = hist_d[i] + CNT_W'({1'b0, g0 == 8'(i)})
                              + CNT_W'({1'b0, g1 == 8'(i)});
      end
    end
  end

  always_comb begin
    n_d         = clear ? '0 : n_q;
    st_d        = clear ? '0 : st_q;
    state_d     = state_q;
    cnt_d       = '0;
    w0_d        = '0;
    s0_d        = '0;
    thr_d       = thr_q;
    thr_valid_d = thr_valid_q && !clear;
    thr_done_d  = 1'b0;
    overrun_d   = overrun_q || (hsync && (state_q == S_SWEEP));

    if (accept) begin
      n_d  = n_d + CNT_W'(2);
      st_d = st_d + SUM_W'(g0) + SUM_W'(g1);
      state_d = (n_d == TOTAL) ? S_SWEEP : S_ACCUM;
    end else if (last_cyc) begin
      state_d = S_DONE;
    end

    if (state_q == S_SWEEP) begin
      cnt_d = cnt_q + 9'd1;
      w0_d  = w0_q;
      s0_d  = s0_q;
      if (sweep_act) begin
        w0_d = w0_q + h_t;
        s0_d = s0_q + SUM_W'(t_w) * SUM_W'(h_t);
      end
    end

    if (last_cyc) begin
      thr_d       = best_v_q ? best_t_q : 8'd0;
      thr_valid_d = 1'b1;
      thr_done_d  = 1'b1;
    end
  end

  // Three-stage compare path behind the running sums.
  always_comb begin
    p0_v_d = sweep_act;
    p0_t_d = t_w;

    prod_a    = PROD_W'(st_q) * PROD_W'(w0_q);
    prod_b    = PROD_W'(n_q) * PROD_W'(s0_q);
    // Only the square is used, so the magnitude stands in for the signed value.
    p1_diff_d = (prod_a >= prod_b) ? (prod_a - prod_b) : (prod_b - prod_a);
    p1_den_d  = DEN_W'(w0_q) * DEN_W'(n_q - w0_q);
    p1_v_d    = p0_v_q && (w0_q != '0) && (w0_q != n_q);
    p1_t_d    = p0_t_q;

    p2_num_d = NUM_W'(p1_diff_q) * NUM_W'(p1_diff_q);
    p2_den_d = p1_den_q;
    p2_v_d   = p1_v_q;
    p2_t_d   = p1_t_q;

    // Cross-multiplied ratio test; strict so ties keep the lowest t.
    cmp_lhs    = CMP_W'(p2_num_q) * CMP_W'(best_den_q);
    cmp_rhs    = CMP_W'(best_num_q) * CMP_W'(p2_den_q);
    best_v_d   = best_v_q && (state_q == S_SWEEP);
    best_t_d   = best_t_q;
    best_num_d = best_num_q;
    best_den_d = best_den_q;
    if ((state_q == S_SWEEP) && p2_v_q && (!best_v_q || (cmp_lhs > cmp_rhs))) begin
      best_v_d   = 1'b1;
      best_t_d   = p2_t_q;
      best_num_d = p2_num_q;
      best_den_d = p2_den_q;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < 256; i++) hist_q[i] <= '0;
    end else begin
      for (int i = 0; i < 256; i++) hist_q[i] <= hist_d[i];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      st_q        <= '0;
      cnt_q       <= '0;
      w0_q        <= '0;
      s0_q        <= '0;
      p0_v_q      <= 1'b0;
      p0_t_q      <= '0;
      p1_v_q      <= 1'b0;
      p1_t_q      <= '0;
      p1_diff_q   <= '0;
      p1_den_q    <= '0;
      p2_v_q      <= 1'b0;
      p2_t_q      <= '0;
      p2_num_q    <= '0;
      p2_den_q    <= '0;
      best_v_q    <= 1'b0;
      best_t_q    <= '0;
      best_num_q  <= '0;
      best_den_q  <= '0;
      thr_q       <= '0;
      thr_valid_q <= 1'b0;
      thr_done_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      w0_q        <= w0_d;
      s0_q        <= s0_d;
      p0_v_q      <= p0_v_d;
      p0_t_q      <= p0_t_d;
      p1_v_q      <= p1_v_d;
      p1_t_q      <= p1_t_d;
      p1_diff_q   <= p1_diff_d;
      p1_den_q    <= p1_den_d;
      p2_v_q      <= p2_v_d;
      p2_t_q      <= p2_t_d;
      p2_num_q    <= p2_num_d;
      p2_den_q    <= p2_den_d;
      best_v_q    <= best_v_d;
      best_t_q    <= best_t_d;
      best_num_q  <= best_num_d;
      best_den_q  <= best_den_d;
      thr_q       <= thr_d;
      thr_valid_q <= thr_valid_d;
      thr_done_q  <= thr_done_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef OTSU_HIST_READ_EN
  logic [CNT_W-1:0] hist_data_q, hist_data_d;

  assign hist_data_d = hist_q[hist_addr];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) hist_data_q <= '0;
    else          hist_data_q <= hist_data_d;
  end

  assign hist_data = hist_data_q;
`endif

  assign THRESHOLD = thr_q;
  assign thr_valid = thr_valid_q;
  assign thr_done  = thr_done_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == S_ACCUM) || (state_q == S_SWEEP);

endmodule

`default_nettype wire

// File: tb/tb_otsu_threshold.sv
// ============================================================================
//  Module   : tb_otsu_threshold
//  Purpose  : Self-checking bench for otsu_threshold (8x4 frame, 16 pairs).
//             Table of frames with hand-computed thresholds, plus hand-written
//             reset and mid-frame reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_otsu_threshold;

  localparam int WIDTH  = 8;
  localparam int HEIGHT = 4;
  localparam int CNT_W  = 20;
  localparam int PAIRS  = WIDTH * HEIGHT / 2;
  localparam int NVEC   = 9;

  logic       HCLK    = 1'b0;
  logic       HRESETn = 1'b0;
  logic       hsync   = 1'b0;
  logic [7:0] DATA_R0 = '0, DATA_G0 = '0, DATA_B0 = '0;
  logic [7:0] DATA_R1 = '0, DATA_G1 = '0, DATA_B1 = '0;
  logic [7:0] THRESHOLD;
  logic       thr_valid, thr_done, busy, overrun;
`ifdef OTSU_HIST_READ_EN
  logic [7:0]       hist_addr = '0;
  logic [CNT_W-1:0] hist_data;
`endif

  otsu_threshold #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .CNT_W(CNT_W)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .hsync     (hsync),
    .DATA_R0   (DATA_R0),
    .DATA_G0   (DATA_G0),
    .DATA_B0   (DATA_B0),
    .DATA_R1   (DATA_R1),
    .DATA_G1   (DATA_G1),
    .DATA_B1   (DATA_B1),
`ifdef OTSU_HIST_READ_EN
    .hist_addr (hist_addr),
    .hist_data (hist_data),
`endif
    .THRESHOLD (THRESHOLD),
    .thr_valid (thr_valid),
    .thr_done  (thr_done),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    string       name;
    logic [23:0] a0, a1, b0, b1, c0, c1;  // {R,G,B} for pixel 0/1 of groups A/B/C
    int          na, nb;                  // pairs in group A and B, rest is C
    logic        gap;                     // idle cycle between pairs
    logic        ovr;                     // hsync pulse during the sweep
    logic [7:0]  exp_thr;
    logic [7:0]  hbin;
    int          hexp;
  } vec_t;

  vec_t vecs [NVEC];
  int   checks   = 0;
  int   failures = 0;
  logic exp_ovr  = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [23:0] gr(input logic [7:0] g);
    return {g, g, g};
  endfunction

  function automatic vec_t mk(input string nm, input logic [23:0] a0, input logic [23:0] a1,
                              input logic [23:0] b0, input logic [23:0] b1,
                              input logic [23:0] c0, input logic [23:0] c1,
                              input int na, input int nb, input logic gap, input logic ovr,
                              input logic [7:0] thr, input logic [7:0] hbin, input int hexp);
    vec_t v;
    v.name = nm; v.a0 = a0; v.a1 = a1; v.b0 = b0; v.b1 = b1; v.c0 = c0; v.c1 = c1;
    v.na = na; v.nb = nb; v.gap = gap; v.ovr = ovr;
    v.exp_thr = thr; v.hbin = hbin; v.hexp = hexp;
    return v;
  endfunction

  task automatic send_pair(input logic [23:0] p0, input logic [23:0] p1);
    @(negedge HCLK);
    hsync = 1'b1;
    {DATA_R0, DATA_G0, DATA_B0} = p0;
    {DATA_R1, DATA_G1, DATA_B1} = p1;
    @(posedge HCLK);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_thr"},     THRESHOLD, 0);
    check({tag, "_valid"},   thr_valid, 0);
    check({tag, "_done"},    thr_done,  0);
    check({tag, "_busy"},    busy,      0);
    check({tag, "_overrun"}, overrun,   0);
`ifdef OTSU_HIST_READ_EN
    check({tag, "_hist"},    hist_data, 0);
`endif
  endtask

  task automatic run_vec(input vec_t v);
    int          lat;
    logic [23:0] p0, p1;
    for (int p = 0; p < PAIRS; p++) begin
      if (p < v.na) begin
        p0 = v.a0; p1 = v.a1;
      end else if (p < v.na + v.nb) begin
        p0 = v.b0; p1 = v.b1;
      end else begin
        p0 = v.c0; p1 = v.c1;
      end
      send_pair(p0, p1);
      if (p == 0) begin
        #1;
        check({v.name, "_valid_drop"}, thr_valid, 0);
        check({v.name, "_busy_accum"}, busy, 1);
      end
      if (v.gap && p != PAIRS - 1) begin
        @(negedge HCLK);
        hsync = 1'b0;
        @(posedge HCLK);
      end
    end
    lat = -1;
    for (int k = 1; k <= 400 && lat < 0; k++) begin
      @(negedge HCLK);
      hsync = v.ovr && (k == 10);
      {DATA_R0, DATA_G0, DATA_B0} = gr(8'd0);
      {DATA_R1, DATA_G1, DATA_B1} = gr(8'd0);
      @(posedge HCLK);
      #1;
      if (k == 128) check({v.name, "_busy_sweep"}, busy, 1);
      if (thr_done) lat = k;
    end
    if (v.ovr) exp_ovr = 1'b1;
    check({v.name, "_latency"}, lat, 260);
    check({v.name, "_thr"},     THRESHOLD, v.exp_thr);
    check({v.name, "_valid"},   thr_valid, 1);
    check({v.name, "_busy_done"}, busy, 0);
    check({v.name, "_overrun"}, overrun, exp_ovr);
    @(posedge HCLK);
    #1;
    check({v.name, "_done_pulse"}, thr_done, 0);
    check({v.name, "_thr_hold"},   THRESHOLD, v.exp_thr);
`ifdef OTSU_HIST_READ_EN
    @(negedge HCLK);
    hist_addr = v.hbin;
    @(posedge HCLK);
    #1;
    check({v.name, "_hist"}, hist_data, v.hexp);
`endif
  endtask

  initial begin
    vecs[0] = mk("uniform",   gr(100), gr(100), 0, 0, 0, 0, 16, 0, 0, 0, 8'd0, 8'd100, 32);
    vecs[1] = mk("bimodal",   gr(50), gr(50), gr(200), gr(200), 0, 0, 8, 8, 0, 0, 8'd50, 8'd50, 16);
    vecs[2] = mk("skew_ovr",  gr(40), gr(40), gr(220), gr(220), 0, 0, 12, 4, 0, 1, 8'd40, 8'd40, 24);
    vecs[3] = mk("collide7",  gr(7), gr(7), 0, 0, 0, 0, 16, 0, 1, 0, 8'd0, 8'd7, 32);
    vecs[4] = mk("convert",   {8'd255, 8'd0, 8'd1}, {8'd255, 8'd0, 8'd1}, gr(200), gr(200), 0, 0,
                 8, 8, 0, 0, 8'd64, 8'd64, 16);
    vecs[5] = mk("splitpair", gr(10), gr(30), 0, 0, 0, 0, 16, 0, 1, 0, 8'd10, 8'd30, 16);
    vecs[6] = mk("threelvl",  gr(20), gr(20), gr(100), gr(100), gr(200), gr(200),
                 8, 4, 0, 0, 8'd100, 8'd100, 8);
    vecs[7] = mk("weights",   {8'd12, 8'd34, 8'd56}, {8'd90, 8'd10, 8'd250}, 0, 0, 0, 0,
                 16, 0, 0, 0, 8'd34, 8'd90, 16);
    vecs[8] = mk("topbins",   gr(254), gr(254), gr(255), gr(255), 0, 0, 8, 8, 0, 0,
                 8'd254, 8'd255, 16);

    // Reset state.
    repeat (3) @(posedge HCLK);
    #1;
    check_all_zero("reset");
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    check_all_zero("post_reset");

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    // Reset in the middle of accumulating a frame.
    for (int p = 0; p < 5; p++) send_pair(gr(120), gr(120));
    @(negedge HCLK);
    hsync   = 1'b0;
    HRESETn = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(posedge HCLK);
    #1;
    check_all_zero("mid_reset_hold");
    exp_ovr = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    run_vec(vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
